if_stage: RTL



---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_stage_if.sv | 14 +
 rtl/if_stage.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package if_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StKill
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN - 2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction memory req/gnt/rvalid handshake between fetch stage (master) and imem (slave).
interface if_stage_if;
    import if_stage_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/if_stage.sv
// RV32I fetch stage: PC, one-deep prefetch buffer and imem request FSM.
// Define MISALIGN_TRAP_EN to redirect misaligned branch targets to TRAP_VEC.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            bl_sel_i,
    input  logic [XLEN-1:0] alu_data_i,
    input  logic            instr_ready_i,
    if_stage_if.master      imem,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_four_o,
    output logic            misalign_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pf_valid_q, pf_valid_d;
    logic [XLEN-1:0] pf_instr_q, pf_instr_d;

    logic            retire;
    logic            redirect;
    logic            rsp;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] target;
    logic [1:0]      occ_d;

    assign retire   = instr_valid_q & instr_ready_i;
    assign redirect = retire & bl_sel_i;
    assign rsp      = (state_q == StWait) & imem.rvalid;
    // fetch_pc has already moved past the word whose response is in flight
    assign rsp_pc   = fetch_pc_q - 32'd4;

`ifdef MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    logic target_misaligned;

    assign target_misaligned = alu_data_i[1:0] != 2'b00;
    assign target            = target_misaligned ? TRAP_VEC : word_align(alu_data_i);
    assign misalign_d        = redirect & target_misaligned;
    assign misalign_o        = misalign_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    logic unused_trap_vec;

    assign unused_trap_vec = ^TRAP_VEC;
    assign target          = word_align(alu_data_i);
    assign misalign_o      = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        pf_valid_d    = pf_valid_q;
        pf_instr_d    = pf_instr_q;

        if (redirect) begin
            // pc_d follows from rsp_pc once the target word returns
            instr_valid_d = 1'b0;
            pf_valid_d    = 1'b0;
            fetch_pc_d    = target;
        end else if (retire) begin
            if (pf_valid_q) begin
                instr_d    = pf_instr_q;
                pc_d       = pc_q + 32'd4;
                pf_valid_d = 1'b0;
            end else if (rsp) begin
                instr_d = imem.rdata;
                pc_d    = rsp_pc;
            end else begin
                instr_valid_d = 1'b0;
            end
        end else if (rsp) begin
            if (!instr_valid_q) begin
                instr_valid_d = 1'b1;
                instr_d       = imem.rdata;
                pc_d          = rsp_pc;
            end else begin
                pf_valid_d = 1'b1;
                pf_instr_d = imem.rdata;
            end
        end

        occ_d = {1'b0, instr_valid_d} + {1'b0, pf_valid_d};

        unique case (state_q)
            StIdle: begin
                if (occ_d != 2'd2) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                // a grant coinciding with a redirect leaves a stale response to drop
                if (imem.gnt) begin
                    if (redirect) begin
                        state_d = StKill;
                    end else begin
                        state_d    = StWait;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
            end
            StWait: begin
                if (imem.rvalid) begin
                    state_d = StIdle;
                end else if (redirect) begin
                    state_d = StKill;
                end
            end
            StKill: begin
                if (imem.rvalid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            fetch_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= NOP;
            pc_q          <= RESET_PC;
            pf_valid_q    <= 1'b0;
            pf_instr_q    <= NOP;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            pf_valid_q    <= pf_valid_d;
            pf_instr_q    <= pf_instr_d;
        end
    end

    assign imem.req      = (state_q == StReq);
    assign imem.addr     = fetch_pc_q;
    assign instr_valid_o = instr_valid_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_q;
    assign pc_four_o     = pc_q + 32'd4;

endmodule
